// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm -- multi-cycle fetch/decode control unit for the 16-bit datapath.
//
// Fetches an instruction word over a ready-handshaked memory port into an
// internal IR. It then presents the register-address fields to the downstream
// 5-bit address latches for one cycle and sequences the ALU, memory and
// writeback strobes. Memory waits in FETCH and MEM are bounded by TIMEOUT.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   instr_in     instruction word, sampled in FETCH when mem_ready=1
//   mem_ready    memory handshake completion (ignored outside FETCH/MEM)
//   mem_req      memory request (FETCH, MEM)
//   mem_we       write qualifier (MEM of a STORE)
//   rdest_addr   IR[9:5] to the rdest address latch
//   rsrc_addr    IR[4:0] to the rsrc address latch
//   addr_en      load enable for both address latches (DECODE only)
//   imm5         IR[4:0] as immediate
//   alu_op       ALU function (EXEC only, else 0)
//   alu_src_imm  ALU B operand select (EXEC of ADDI)
//   wb_en        register-file write strobe (WB)
//   pc_en        PC increment strobe (WB)
//   halted       high in HALT
//   illegal_op   one-cycle pulse in DECODE on an unknown opcode
//   mem_err      one-cycle pulse when a memory wait times out
//
// Parameters
//   TIMEOUT      max wait cycles for mem_ready; 0 disables the timeout
//   CNTW         wait counter width, must hold TIMEOUT

module cpu_ctrl_fsm #(
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [4:0]  rdest_addr,
  output logic [4:0]  rsrc_addr,
  output logic        addr_en,
  output logic [4:0]  imm5,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        wb_en,
  output logic        pc_en,
  output logic        halted,
  output logic        illegal_op,
  output logic        mem_err
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000011;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b000101;
  localparam logic [5:0] OP_LOAD  = 6'b001000;
  localparam logic [5:0] OP_STORE = 6'b001001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam bit            TMO_EN = (TIMEOUT != 0);
  localparam logic [CNTW-1:0] TMO  = CNTW'(TIMEOUT);

  logic [2:0]      state, state_nxt;
  logic [15:0]     ir;
  logic [CNTW-1:0] cnt;
  // Remembers that the MEM phase was abandoned so WB suppresses the write.
  logic            mem_abort;

  logic [5:0] opcode;
  assign opcode = ir[15:10];

  // Opcode classification
  logic       op_alu, op_imm, op_load, op_store, op_halt, op_nop, op_ill, op_wr;
  logic [2:0] op_fn;

  always_comb begin
    op_alu   = 1'b0;
    op_imm   = 1'b0;
    op_load  = 1'b0;
    op_store = 1'b0;
    op_halt  = 1'b0;
    op_nop   = 1'b0;
    op_ill   = 1'b0;
    op_fn    = 3'b000;
    case (opcode)
      OP_NOP:   op_nop   = 1'b1;
      OP_ADD:   begin op_alu = 1'b1; op_fn = 3'b000; end
      OP_SUB:   begin op_alu = 1'b1; op_fn = 3'b001; end
      OP_AND:   begin op_alu = 1'b1; op_fn = 3'b010; end
      OP_OR:    begin op_alu = 1'b1; op_fn = 3'b011; end
      OP_ADDI:  begin op_alu = 1'b1; op_fn = 3'b000; op_imm = 1'b1; end
      OP_LOAD:  op_load  = 1'b1;
      OP_STORE: op_store = 1'b1;
      OP_HALT:  op_halt  = 1'b1;
      default:  op_ill   = 1'b1;
    endcase
    op_wr = op_alu | op_load;
  end

  // Wait handling shared by FETCH and MEM. A ready in the same cycle as
  // the counter reaching TIMEOUT completes normally.
  logic waiting, tmo_hit;
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign tmo_hit = TMO_EN && waiting && !mem_ready && (cnt == TMO);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (op_halt)               state_nxt = S_HALT;
        else if (op_nop || op_ill) state_nxt = S_WB;
        else                       state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = (op_load || op_store) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready || tmo_hit) state_nxt = S_WB;
      S_WB:     state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      cnt       <= '0;
      mem_abort <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ready) ir <= instr_in;
      if (waiting) begin
        if (mem_ready || tmo_hit) cnt <= '0;
        else                      cnt <= cnt + 1'b1;
      end
      if (state == S_MEM && tmo_hit) mem_abort <= 1'b1;
      else if (state == S_WB)        mem_abort <= 1'b0;
    end
  end

  // Outputs. mem_req is gated by reset so nothing is requested while the
  // unit is held in reset, even though the state register already reads FETCH.
  assign mem_req     = waiting && reset;
  assign mem_we      = (state == S_MEM) && op_store;
  assign rdest_addr  = ir[9:5];
  assign rsrc_addr   = ir[4:0];
  assign imm5        = ir[4:0];
  assign addr_en     = (state == S_DECODE);
  assign alu_op      = (state == S_EXEC) ? op_fn : 3'b000;
  assign alu_src_imm = (state == S_EXEC) && op_imm;
  assign wb_en       = (state == S_WB) && op_wr && !mem_abort;
  assign pc_en       = (state == S_WB);
  assign halted      = (state == S_HALT);
  assign illegal_op  = (state == S_DECODE) && op_ill;
  assign mem_err     = tmo_hit;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
module tb_cpu_ctrl_fsm;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_in = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, addr_en, alu_src_imm, wb_en, pc_en, halted, illegal_op, mem_err;
  logic [4:0]  rdest_addr, rsrc_addr, imm5;
  logic [2:0]  alu_op;

  cpu_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNTW(4)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .rdest_addr(rdest_addr), .rsrc_addr(rsrc_addr),
    .addr_en(addr_en), .imm5(imm5), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .wb_en(wb_en), .pc_en(pc_en), .halted(halted), .illegal_op(illegal_op), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we;
    logic [4:0] rdest, rsrc;
    logic       addr_en;
    logic [4:0] imm5;
    logic [2:0] alu_op;
    logic       alu_src_imm, wb_en, pc_en, halted, illegal_op, mem_err;
  } outv_t;

  outv_t act;
  always_comb begin
    act.mem_req     = mem_req;
    act.mem_we      = mem_we;
    act.rdest       = rdest_addr;
    act.rsrc        = rsrc_addr;
    act.addr_en     = addr_en;
    act.imm5        = imm5;
    act.alu_op      = alu_op;
    act.alu_src_imm = alu_src_imm;
    act.wb_en       = wb_en;
    act.pc_en       = pc_en;
    act.halted      = halted;
    act.illegal_op  = illegal_op;
    act.mem_err     = mem_err;
  end

  int checks = 0;
  int errors = 0;
  outv_t expq[$];
  outv_t hist[0:1023];
  int npush = 0;
  int npop  = 0;
  logic [15:0] ir_m = '0;

  // Per-cycle compare against the model's expected output vector.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      outv_t e;
      e = expq.pop_front();
      hist[npop] = act;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL cycle[%0d] got=%h want=%h", npop, act, e);
      end
      npop++;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic outv_t idle_v(input logic [15:0] ir);
    outv_t e;
    e = '0;
    e.rdest = ir[9:5];
    e.rsrc  = ir[4:0];
    e.imm5  = ir[4:0];
    return e;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic rdy, input logic [15:0] ins, input outv_t e);
    mem_ready = rdy;
    instr_in  = ins;
    expq.push_back(e);
    npush++;
    @(posedge clk); #1;
  endtask

  // Instruction-level model: fwait not-ready cycles in FETCH, mwait in MEM.
  task automatic run(input logic [15:0] ins, input int fwait, input int mwait);
    outv_t e;
    int k;
    logic [5:0] op;
    logic ill, hlt, nop, alu, mem, st, wr, imm, abort;
    logic [2:0] aop;
    k = 0;
    for (int i = 0; i < fwait; i++) begin
      e = idle_v(ir_m);
      e.mem_req = 1'b1;
      e.mem_err = (TIMEOUT != 0) && (k == TIMEOUT);
      k = e.mem_err ? 0 : k + 1;
      step(1'b0, ins, e);
    end
    e = idle_v(ir_m);
    e.mem_req = 1'b1;
    step(1'b1, ins, e);
    ir_m = ins;
    op = ins[15:10];
    {ill, hlt, nop, alu, mem, st, wr, imm} = '0;
    aop = 3'b000;
    case (op)
      6'd0:  nop = 1'b1;
      6'd1:  begin alu = 1'b1; wr = 1'b1; aop = 3'd0; end
      6'd2:  begin alu = 1'b1; wr = 1'b1; aop = 3'd1; end
      6'd3:  begin alu = 1'b1; wr = 1'b1; aop = 3'd2; end
      6'd4:  begin alu = 1'b1; wr = 1'b1; aop = 3'd3; end
      6'd5:  begin alu = 1'b1; wr = 1'b1; aop = 3'd0; imm = 1'b1; end
      6'd8:  begin mem = 1'b1; wr = 1'b1; end
      6'd9:  begin mem = 1'b1; st = 1'b1; end
      6'd63: hlt = 1'b1;
      default: ill = 1'b1;
    endcase
    e = idle_v(ir_m);
    e.addr_en = 1'b1;
    e.illegal_op = ill;
    step(1'b1, 16'hFFFF, e);
    if (hlt) return;
    if (alu || mem) begin
      e = idle_v(ir_m);
      e.alu_op = aop;
      e.alu_src_imm = imm;
      step(1'b1, 16'hFFFF, e);
    end
    abort = 1'b0;
    if (mem) begin
      for (int i = 0; ; i++) begin
        e = idle_v(ir_m);
        e.mem_req = 1'b1;
        e.mem_we  = st;
        if (i == mwait) begin
          step(1'b1, 16'hFFFF, e);
          break;
        end
        e.mem_err = (TIMEOUT != 0) && (i == TIMEOUT);
        step(1'b0, 16'hFFFF, e);
        if (e.mem_err) begin
          abort = 1'b1;
          break;
        end
      end
    end
    e = idle_v(ir_m);
    e.pc_en = 1'b1;
    e.wb_en = wr && !abort;
    step(1'b1, 16'hFFFF, e);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("rst_outputs", 32'(act), 32'(outv_t'('0)));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_release_mem_req", 32'(mem_req), 32'd1);
    chk("rst_release_ir", {22'd0, rdest_addr, rsrc_addr}, 32'd0);
    ir_m = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    int s;
    outv_t e;
    mem_ready = 1'b0;
    #3;
    chk("reset_hold", 32'(act), 32'(outv_t'('0)));
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("reset_mem_req", 32'(mem_req), 32'd1);

    // ADD r2, r3
    s = npush;
    run(16'h0443, 0, 0);
    chk("add_addr_en", 32'(hist[s+1].addr_en), 32'd1);
    chk("add_rdest", 32'(hist[s+1].rdest), 32'd2);
    chk("add_rsrc", 32'(hist[s+1].rsrc), 32'd3);
    chk("add_alu_op", 32'(hist[s+2].alu_op), 32'd0);
    chk("add_wb_pc", {hist[s+3].wb_en, hist[s+3].pc_en}, 32'd3);

    s = npush;
    run(16'h0864, 0, 0);
    chk("sub_alu_op", 32'(hist[s+2].alu_op), 32'd1);
    run(16'h0C21, 2, 0);
    run(16'h1042, 0, 0);
    s = npush;
    run(16'h141F, 0, 0);
    chk("addi_imm", {hist[s+2].alu_src_imm, hist[s+2].imm5}, 32'h3F);

    // LOAD with ready three cycles into MEM
    s = npush;
    run(16'h2025, 0, 3);
    chk("load_mem_req4", {hist[s+3].mem_req, hist[s+4].mem_req, hist[s+5].mem_req, hist[s+6].mem_req, hist[s+7].mem_req}, 32'b11110);
    chk("load_mem_we", 32'(hist[s+4].mem_we), 32'd0);
    chk("load_wb_en", 32'(hist[s+7].wb_en), 32'd1);

    // STORE
    s = npush;
    run(16'h2400, 0, 0);
    chk("store_mem_we", 32'(hist[s+3].mem_we), 32'd1);
    chk("store_wb_en", {hist[s+4].wb_en, hist[s+4].pc_en}, 32'd1);

    // Fetch timeout and ready-on-boundary
    s = npush;
    run(16'h0000, 16, 0);
    chk("fetch_tmo_err", {hist[s+14].mem_err, hist[s+15].mem_err, hist[s+16].mem_err}, 32'b010);
    s = npush;
    run(16'h0443, 15, 0);
    chk("fetch_ready_wins", 32'(hist[s+15].mem_err), 32'd0);
    run(16'h0000, 35, 0);

    // MEM timeout aborts the write but still advances the PC
    s = npush;
    run(16'h2025, 0, 16);
    chk("mem_tmo_err", 32'(hist[s+18].mem_err), 32'd1);
    chk("mem_tmo_wb", {hist[s+19].wb_en, hist[s+19].pc_en}, 32'd1);
    s = npush;
    run(16'h2025, 0, 15);
    chk("mem_ready_wins", {hist[s+18].mem_err, hist[s+19].wb_en}, 32'b01);

    // Illegal opcode 010101
    s = npush;
    run(16'h5422, 0, 0);
    chk("illegal_pulse", {hist[s+1].illegal_op, hist[s+2].illegal_op}, 32'b10);
    chk("illegal_wb", {hist[s+2].wb_en, hist[s+2].pc_en}, 32'd1);

    // Reset while in EXEC
    e = idle_v(ir_m); e.mem_req = 1'b1;
    step(1'b1, 16'h0443, e);
    ir_m = 16'h0443;
    e = idle_v(ir_m); e.addr_en = 1'b1;
    step(1'b1, 16'hFFFF, e);
    mem_ready = 1'b1;
    do_reset();
    run(16'h0443, 0, 0);

    // HALT persists until reset
    s = npush;
    run(16'hFC00, 0, 0);
    for (int i = 0; i < 6; i++) begin
      e = idle_v(ir_m);
      e.halted = 1'b1;
      step(i[0], 16'h0443, e);
    end
    chk("halt_persist", {hist[s+2].halted, hist[s+7].halted, hist[s+7].pc_en}, 32'b110);
    do_reset();
    run(16'h0864, 1, 0);

    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
Multi-cycle fetch/decode control unit for the 16-bit datapath. It fetches an instruction word over a ready-handshaked memory port and latches it in an internal IR. It then drives the 5-bit register-address fields and their load enable into the downstream 5-bit address latches (rdest/rsrc), and sequences ALU, memory and writeback strobes. It also includes a bounded memory-wait timeout.

Parameters:
TIMEOUT, 15, max cycles to wait for mem_ready in FETCH/MEM; 0 disables timeout
CNTW, 4, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
instr_in  in  16  instruction word from memory, valid when mem_ready=1 in FETCH
mem_ready  in  1  memory handshake completion
mem_req  out  1  memory request (FETCH, MEM)
mem_we  out  1  write qualifier, 1 only in MEM for STORE
rdest_addr  out  5  IR[9:5], to rdest address latch datain
rsrc_addr  out  5  IR[4:0], to rsrc address latch datain
addr_en  out  1  enableReg for both address latches
imm5  out  5  IR[4:0] as immediate
alu_op  out  3  ALU function
alu_src_imm  out  1  1 = ALU B operand is imm5
wb_en  out  1  register-file write strobe
pc_en  out  1  PC increment strobe
halted  out  1  1 in HALT state
illegal_op  out  1  one-cycle pulse on unknown opcode
mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Instruction format: opcode=IR[15:10], rdest=IR[9:5], rsrc/imm=IR[4:0].
- Opcodes: 000000 NOP; 000001 ADD(alu 000); 000010 SUB(001); 000011 AND(010); 000100 OR(011); 000101 ADDI(000, imm); 001000 LOAD; 001001 STORE; 111111 HALT. All others are illegal and execute as NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Register state/IR/counter; outputs are combinational from state and IR (Moore).
- Reset (reset=0, async): state=FETCH, IR=0, wait counter=0. All outputs 0 except mem_req, which is 1 once reset deasserts because state is FETCH. Reset mid-operation abandons the instruction; no wb_en or pc_en is issued.
- FETCH: mem_req=1. On mem_ready=1, latch IR<=instr_in, clear counter, go to DECODE. Otherwise increment counter.
- DECODE: addr_en=1 for exactly one cycle. rdest_addr/rsrc_addr are valid this cycle, so the latches capture them at the next edge.
- DECODE next state: HALT opcode -> HALT. NOP or illegal -> WB, with illegal_op=1 in this DECODE cycle for an illegal opcode. Everything else -> EXEC.
- EXEC: alu_op and alu_src_imm are valid for one cycle. Next state: LOAD/STORE -> MEM; others -> WB.
- MEM: mem_req=1; mem_we=1 for STORE only. Wait for mem_ready with the same counter rules as FETCH, then go to WB.
- WB: pc_en=1 for one cycle. wb_en=1 only for ADD/SUB/AND/OR/ADDI/LOAD. Next state is FETCH.
- HALT: halted=1 and all strobes are 0. The FSM stays in HALT until reset.
- Minimum latency: ALU instruction 4 cycles (FETCH with immediate ready, DECODE, EXEC, WB); LOAD/STORE 5 cycles; NOP/illegal 3 cycles.
- Timeout: if TIMEOUT!=0 and the counter reaches TIMEOUT while waiting, pulse mem_err for one cycle and clear the counter.
  - In FETCH: re-issue the fetch (stay in FETCH); pc_en is not pulsed.
  - In MEM: go to WB with wb_en forced 0 and pc_en=1.
- mem_ready in the same cycle as counter==TIMEOUT: ready wins and there is no error.
- mem_ready outside FETCH/MEM is ignored.
- alu_op/alu_src_imm are 0 outside EXEC. The address outputs always reflect IR; only addr_en qualifies them.

Test Plan:
- Reset: hold reset=0 mid-EXEC -> all strobes 0 asynchronously. Release -> mem_req=1, state FETCH, IR=0.
- ADD 16'h0443 (rdest=2, rsrc=3), mem_ready tied 1 -> addr_en in cycle 2 with rdest_addr=2, rsrc_addr=3. alu_op=000 in cycle 3. wb_en=1 and pc_en=1 in cycle 4.
- LOAD 16'h2025 with mem_ready asserted 3 cycles into MEM -> mem_we=0, mem_req held 4 cycles, then wb_en=1.
- STORE 16'h2400 -> mem_we=1 in MEM and wb_en=0 in WB.
- TIMEOUT=15 with mem_ready held 0 -> mem_err pulses after 15 wait cycles, FSM stays in FETCH. Ready on cycle 15 -> no mem_err.
- Opcode 010101 -> illegal_op pulse in DECODE, no wb_en, pc_en=1. Opcode 111111 -> halted=1 persists until reset.
